// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned CFG_W = 16;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } clk_div_cfg_t;

  // Roughly 50% duty, rounding the high phase up for odd divisors.
  function automatic int unsigned default_high(input int unsigned div);
    return div - (div >> 1);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write port of the clock divider bank (valid/ready).
interface clk_div_bank_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow settings, boundary-only apply.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = CFG_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               sync_i,
  input  logic               wr_i,
  input  logic [2*WIDTH-1:0] cfg,
  output logic               pend_o,
  output logic               clk_o,
  output logic               tick_o
);

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] high;
  } cfg_t;

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(default_high(DEFAULT_DIV));

  cfg_t             w_cfg;
  logic [WIDTH-1:0] r_div, r_high, r_sdiv, r_shigh, r_cnt;
  logic             r_pend, r_clk, r_tick;
  logic [WIDTH-1:0] w_eff_high;
  logic             w_wrap, w_stop, w_apply;

  assign w_cfg = cfg;

  always_comb begin
    w_eff_high = (r_high > r_div) ? r_div : r_high;
    // div-1 is only meaningful for a nonzero divisor
    w_wrap     = (r_div != '0) && (r_cnt == r_div - WIDTH'(1));
    w_stop     = !en_i || (r_div == '0);
    w_apply    = r_pend && (w_stop || sync_i || w_wrap);
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= RST_DIV;
      r_high  <= RST_HIGH;
      r_sdiv  <= RST_DIV;
      r_shigh <= RST_HIGH;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      if (w_stop || sync_i) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_tick <= (r_cnt == '0);
        r_clk  <= (r_cnt >= r_div - w_eff_high);
        r_cnt  <= w_wrap ? '0 : r_cnt + WIDTH'(1);
      end
      // A write is only accepted while nothing is pending, so it never meets an apply.
      if (w_apply) begin
        r_div  <= r_sdiv;
        r_high <= r_shigh;
        r_pend <= 1'b0;
      end else if (wr_i && !r_pend) begin
        r_sdiv  <= w_cfg.div;
        r_shigh <= w_cfg.high;
        r_pend  <= 1'b1;
      end
    end
  end

  assign pend_o = r_pend;
  assign clk_o  = r_clk;
  assign tick_o = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH runtime-programmable clock dividers sharing one config port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned WIDTH       = CFG_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  clk_div_bank_if.slave    cfg,
  output logic [NCH-1:0]   clk_o,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   pending_o
);

  logic [NCH-1:0]     w_pend;
  logic [NCH-1:0]     w_wr;
  logic [2*WIDTH-1:0] w_cfg;
  logic               w_ch_ok;

  assign w_cfg   = {cfg.cfg_div, cfg.cfg_high};
  assign w_ch_ok = (32'(cfg.cfg_ch) < NCH);
  // Out-of-range channel writes are acknowledged and dropped.
  assign cfg.cfg_ready = w_ch_ok ? !w_pend[cfg.cfg_ch] : 1'b1;

  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_wr[i] = cfg.cfg_valid && cfg.cfg_ready && (32'(cfg.cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .en_i    (en_i[g]),
      .sync_i  (sync_i),
      .wr_i    (w_wr[g]),
      .cfg     (w_cfg),
      .pend_o  (w_pend[g]),
      .clk_o   (clk_o[g]),
      .tick_o  (tick_o[g])
    );
  end

  assign pending_o = w_pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table, corner sequences, random vs model.
module tb_clk_div_bank;
  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 16;

  logic             clk_i   = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH-1:0]   en      = '0;
  logic             sync    = 1'b0;
  logic [NCH-1:0]   clk_o, tick_o, pending_o;

  clk_div_bank_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg_if ();

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .en_i      (en),
    .sync_i    (sync),
    .cfg       (cfg_if),
    .clk_o     (clk_o),
    .tick_o    (tick_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase = cycles since period start, modulo divisor.
  int             m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
  longint         m_t0[NCH];
  logic [NCH-1:0] m_pend, m_clk, m_tick;
  longint         n_edge = 0;

  always @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = 2; m_high[c] = 1; m_sdiv[c] = 2; m_shigh[c] = 1;
        m_t0[c] = n_edge;
      end
      m_pend = '0; m_clk = '0; m_tick = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit     acc;
        longint ph;
        int     eh;
        acc = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == c) && !m_pend[c];
        if (!en[c] || m_div[c] == 0 || sync) begin
          m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_t0[c] = n_edge + 1;
          if (m_pend[c]) begin
            m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 1'b0;
          end
        end else begin
          ph = (n_edge - m_t0[c]) % m_div[c];
          eh = (m_high[c] < m_div[c]) ? m_high[c] : m_div[c];
          m_tick[c] = (ph == 0);
          m_clk[c]  = (ph >= m_div[c] - eh);
          if (ph == m_div[c] - 1 && m_pend[c]) begin
            m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 1'b0;
            m_t0[c] = n_edge + 1;
          end
        end
        if (acc) begin
          m_sdiv[c] = int'(cfg_if.cfg_div); m_shigh[c] = int'(cfg_if.cfg_high); m_pend[c] = 1'b1;
        end
      end
      n_edge++;
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
    chk("model_clk", clk_o, m_clk);
    chk("model_tick", tick_o, m_tick);
    chk("model_pend", pending_o, m_pend);
    chk("model_ready", cfg_if.cfg_ready, !m_pend[cfg_if.cfg_ch]);
  endtask

  task automatic wr(input logic v, input int ch, input int d, input int h);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 16'(d);
    cfg_if.cfg_high  = 16'(h);
  endtask

  typedef struct {
    logic [3:0] en;
    logic       valid;
    int         div;
    int         high;
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_pend;
    logic       e_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int waited;
    tbl[0] = '{4'hF, 1'b0, 0, 0, 4'h0, 4'hF, 4'h0, 1'b1};
    tbl[1] = '{4'hF, 1'b0, 0, 0, 4'hF, 4'h0, 4'h0, 1'b1};
    tbl[2] = '{4'hF, 1'b1, 5, 2, 4'h0, 4'hF, 4'h1, 1'b0};
    tbl[3] = '{4'hF, 1'b0, 0, 0, 4'hF, 4'h0, 4'h0, 1'b1};
    tbl[4] = '{4'hF, 1'b0, 0, 0, 4'h0, 4'hF, 4'h0, 1'b1};
    tbl[5] = '{4'hF, 1'b0, 0, 0, 4'hE, 4'h0, 4'h0, 1'b1};
    tbl[6] = '{4'hF, 1'b0, 0, 0, 4'h0, 4'hE, 4'h0, 1'b1};
    tbl[7] = '{4'hF, 1'b0, 0, 0, 4'hF, 4'h0, 4'h0, 1'b1};
    tbl[8] = '{4'hF, 1'b0, 0, 0, 4'h1, 4'hE, 4'h0, 1'b1};
    tbl[9] = '{4'hF, 1'b0, 0, 0, 4'hE, 4'h1, 4'h0, 1'b1};

    wr(1'b0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("rst_clk", clk_o, 4'h0);
    chk("rst_tick", tick_o, 4'h0);
    chk("rst_pend", pending_o, 4'h0);
    reset_n = 1'b1;
    chk("rst_ready", cfg_if.cfg_ready, 1'b1);

    // Defaults, then ch0 reprogrammed to div=5 high=2
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      wr(tbl[i].valid, 0, tbl[i].div, tbl[i].high);
      cycle();
      chk($sformatf("vec%0d_clk", i), clk_o, tbl[i].e_clk);
      chk($sformatf("vec%0d_tick", i), tick_o, tbl[i].e_tick);
      chk($sformatf("vec%0d_pend", i), pending_o, tbl[i].e_pend);
      chk($sformatf("vec%0d_ready", i), cfg_if.cfg_ready, tbl[i].e_ready);
    end

    // Constant-low, constant-high and div=1 channels
    wr(1'b1, 1, 4, 0); cycle();
    wr(1'b1, 2, 4, 9); cycle();
    wr(1'b1, 3, 1, 1); cycle();
    wr(1'b0, 0, 0, 0);
    repeat (3) cycle();
    chk("edge_pend_clear", pending_o, 4'h0);
    sync = 1'b1; cycle(); sync = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk($sformatf("low_clk_k%0d", k), clk_o[1], 1'b0);
      chk($sformatf("low_tick_k%0d", k), tick_o[1], ((k - 1) % 4) == 0);
      chk($sformatf("high_clk_k%0d", k), clk_o[2], 1'b1);
      chk($sformatf("high_tick_k%0d", k), tick_o[2], ((k - 1) % 4) == 0);
      chk($sformatf("div1_clk_k%0d", k), clk_o[3], 1'b1);
      chk($sformatf("div1_tick_k%0d", k), tick_o[3], 1'b1);
    end

    // Unaligned channels, pending ch0 applied by sync
    wr(1'b1, 1, 3, 1); cycle();
    wr(1'b1, 2, 5, 2); cycle();
    wr(1'b1, 3, 7, 3); cycle();
    wr(1'b0, 0, 0, 0);
    repeat (10) cycle();
    wr(1'b1, 0, 9, 4); cycle();
    wr(1'b0, 0, 0, 0);
    waited = 0;
    while (pending_o[0] && waited < 20) begin
      cycle();
      waited++;
    end
    chk("ch0_div9_applied", pending_o[0], 1'b0);
    wr(1'b1, 0, 3, 1); cycle();
    chk("sync_pre_pend", pending_o[0], 1'b1);
    wr(1'b0, 0, 0, 0);
    sync = 1'b1; cycle(); sync = 1'b0;
    chk("sync_edge_clk", clk_o, 4'h0);
    chk("sync_edge_tick", tick_o, 4'h0);
    chk("sync_pend_clear", pending_o[0], 1'b0);
    cycle();
    chk("sync_tick_all", tick_o, 4'hF);
    chk("sync_tick_clk", clk_o, 4'h0);

    // Reset mid-period with a pending config
    wr(1'b1, 0, 9, 4); cycle();
    wr(1'b0, 0, 0, 0);
    chk("rst_mid_pend_before", pending_o[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_clk", clk_o, 4'h0);
    chk("rst_mid_tick", tick_o, 4'h0);
    chk("rst_mid_pend", pending_o, 4'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n = 1'b1;
    chk("rst_mid_ready", cfg_if.cfg_ready, 1'b1);
    cycle();
    chk("rst_rel_tick", tick_o, 4'hF);
    chk("rst_rel_clk0", clk_o, 4'h0);
    cycle();
    chk("rst_rel_clk1", clk_o, 4'hF);
    chk("rst_rel_pend", pending_o, 4'h0);

    // Config while disabled, then re-enable
    en = 4'b1101; cycle();
    chk("dis_clk", clk_o[1], 1'b0);
    chk("dis_tick", tick_o[1], 1'b0);
    wr(1'b1, 1, 6, 3); cycle();
    wr(1'b0, 0, 0, 0);
    chk("dis_pend_set", pending_o[1], 1'b1);
    cycle();
    chk("dis_pend_applied", pending_o[1], 1'b0);
    en = 4'hF;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk($sformatf("reen_tick_k%0d", k), tick_o[1], (k % 6) == 0);
      chk($sformatf("reen_clk_k%0d", k), clk_o[1], (k % 6) >= 3);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 31) == 0) en[c] = ~en[c];
      end
      sync = ($urandom_range(0, 39) == 0);
      wr($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
         int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of `NCH` independent, runtime-programmable clock dividers for uniboard peripheral timing (PWM bases, serial bit clocks, sampling ticks). Each channel produces a divided clock `clk_o[ch]` with programmable period and high time, plus a one-cycle `tick_o[ch]` strobe at each period start. New settings load through a valid/ready port and take effect only at a period boundary, so outputs never glitch. A shared `sync_i` strobe phase-aligns all channels.

## Interface
- `NCH`, 4: number of divider channels (1..16)
- `WIDTH`, 16: divisor / high-count width in bits
- `DEFAULT_DIV`, 2: divisor loaded at reset; default high count is `DEFAULT_DIV - (DEFAULT_DIV>>1)`

- `clk_i`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `en_i`  in  NCH  per-channel run enable
- `sync_i`  in  1  one-cycle phase-align strobe, applies to all channels
- `cfg_valid_i`  in  1  config write request
- `cfg_ready_o`  out  1  config write accepted this cycle when high with `cfg_valid_i`
- `cfg_ch_i`  in  $clog2(NCH) (min 1)  target channel
- `cfg_div_i`  in  WIDTH  new divisor (period in `clk_i` cycles)
- `cfg_high_i`  in  WIDTH  new high time in cycles
- `clk_o`  out  NCH  divided clocks
- `tick_o`  out  NCH  period-start strobes
- `pending_o`  out  NCH  channel holds a not-yet-applied config

## Operation
- Per channel: active regs `div`, `high`; shadow regs `sdiv`, `shigh`; flag `pend`; counter `cnt` (WIDTH bits).
- Running (`en_i`=1, `div`>=2): `cnt` counts 0..`div`-1 and wraps to 0. `clk_o` <= (`cnt` >= `div`-`eff_high`), where `eff_high` = min(`high`,`div`). Low phase first, then high. `tick_o` <= (`cnt` == 0).
- `high`=0 gives constant low; `high`>=`div` gives constant high. `tick_o` still pulses once per period.
- `div`=1: `cnt` stays 0, `tick_o` is high every cycle, and `clk_o` = (`high`>=1).
- `div`=0: channel is stopped. `cnt`=0, `clk_o`=0, `tick_o`=0.
- Disabled (`en_i`=0): `cnt`<=0, `clk_o`<=0, `tick_o`<=0. A pending config applies on the next edge.
- Config handshake:
  - `cfg_ready_o` = !`pend[cfg_ch_i]`.
  - On accept, `sdiv`/`shigh` <= the inputs and `pend` <= 1.
  - `cfg_ch_i` >= `NCH` is accepted and discarded.
- Apply event: the edge where `cnt` == `div`-1 (wrap), where the channel is disabled or stopped, or where `sync_i`=1. On apply: `div`/`high` <= shadow, `pend` <= 0, `cnt` <= 0. The new period starts on the next cycle with `tick_o`.
- `sync_i`: every enabled channel gets `cnt`<=0, `clk_o`<=0 and applies any pending config. `tick_o` asserts on the cycle after the sync edge.
- Simultaneous cases:
  - Config accept on the same edge as an apply for that channel: the accept is impossible, because `ready` is low while `pend`=1. If `pend`=0, the write lands in the shadow and applies at the next event.
  - `sync_i` together with a wrap: identical outcome.
- Reset (asserted any time, including mid-period):
  - All `cnt`=0, `clk_o`=0, `tick_o`=0, `pend`=0.
  - `div`=`DEFAULT_DIV`, `high`=default; `cfg_ready_o` reads 1 after release.
- Width: all compares are unsigned WIDTH-bit. `div`-1 is evaluated only when `div`>=1.

## Timing
- All outputs are registered; there is no combinational path from inputs to `clk_o`/`tick_o`.
- `cfg_ready_o` is combinational from `cfg_ch_i` and `pend`.
- Enable rising at edge E: the first `tick_o` is at E+1 and `clk_o` is low at E+1.
- Period is exactly `div` cycles; high time is exactly `eff_high` cycles; duty is cycle-exact.
- Config latency: applies at the first wrap after acceptance, at most `div` cycles later. The new period's first `tick_o` follows that edge by one cycle.
- `pending_o` = `pend`, registered.

## Structure
- Package `clk_div_pkg`:
  - `typedef struct packed {div; high}` for `clk_div_cfg_t`, with width set by a package `localparam`; the top overrides it via a parameterised struct or split fields.
  - Helper function `default_high(div)`.
- Sub-module `clk_div_chan`: one channel holding counter, active/shadow regs, apply logic and outputs. Ports: `clk_i`, `reset_n`, `en_i`, `sync_i`, `wr_i`, `cfg`, `pend_o`, `clk_o`, `tick_o`.
- Top `clk_div_bank`: generate loop over `NCH`, channel decode, `cfg_ready_o` mux.

## Test plan
- Reset release, `en_i`=all 1, defaults (`DEFAULT_DIV`=2) -> every `clk_o` toggles 0,1,0,1; `tick_o` high on each `clk_o`=0 cycle; `pending_o`=0.
- Ch0 set to div=5, high=2 while running div=2 -> `pending_o[0]`=1 and `cfg_ready_o` low for ch0 until the next wrap. Afterwards `clk_o[0]` repeats 0,0,0,1,1 with `tick_o` on the first 0.
- Ch1 div=4 high=0, ch2 div=4 high=9, ch3 div=1 high=1 -> ch1 is constantly low, ch2 constantly high, both with a tick every 4 cycles; ch3 is constantly high with a tick every cycle.
- Channels at div=3/5/7 running unaligned; pulse `sync_i` -> all `tick_o` assert together on the next cycle. A pending config on ch0 applies at the sync, and `pending_o[0]` clears.
- Assert `reset_n`=0 mid-period with ch0 pending div=9 -> all outputs go 0 immediately. After release, ch0 runs at `DEFAULT_DIV` and the pending config is lost.
- Drop `en_i[1]` mid-period, write div=6 high=3, then re-enable -> the config applies while disabled. `tick_o[1]` is one cycle after enable; then 3 low, 3 high, repeating.
